// File: rtl/color_detect_pkg.sv
// color_detect_pkg: shared widths, defaults and types for the colour bounding-box tracker
package color_detect_pkg;
    localparam int COORD_W = 12;
    localparam int COUNT_W = 21;
    localparam int MIN_COUNT_DEFAULT = 64;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COUNT_W-1:0] count_t;
    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;
endpackage

// File: rtl/color_bbox_tracker_if.sv
// color_bbox_tracker_if: binary pixel stream in, per-frame bounding box results out
interface color_bbox_tracker_if;
    import color_detect_pkg::*;
    logic pix_valid;
    logic sof;
    logic eol;
    logic binary_in;
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
    count_t pix_count;
    logic bbox_valid;
    logic frame_done;
    modport master (
        output pix_valid, sof, eol, binary_in,
        input x_min, x_max, y_min, y_max, pix_count, bbox_valid, frame_done
    );
    modport slave (
        input pix_valid, sof, eol, binary_in,
        output x_min, x_max, y_min, y_max, pix_count, bbox_valid, frame_done
    );
endinterface

// File: rtl/bbox_axis_minmax.sv
// bbox_axis_minmax: running min/max of one axis; min/max outputs already include the current beat
module bbox_axis_minmax
    import color_detect_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   update,
    input  coord_t coord,
    output coord_t min,
    output coord_t max
);
    coord_t acc_min;
    coord_t acc_max;
    coord_t base_min;
    coord_t base_max;
    // clear restarts from the empty range so a pixel on the clearing beat is still counted
    always_comb begin
        base_min = clear ? '1 : acc_min;
        base_max = clear ? '0 : acc_max;
        min = (update && coord < base_min) ? coord : base_min;
        max = (update && coord > base_max) ? coord : base_max;
    end
    // hold the accumulated range between beats
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_min <= '1;
            acc_max <= '0;
        end else begin
            acc_min <= min;
            acc_max <= max;
        end
    end
endmodule

// File: rtl/color_bbox_tracker.sv
// color_bbox_tracker: bounding box and pixel count of matching pixels, reported once per frame
module color_bbox_tracker
    import color_detect_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int MIN_COUNT = MIN_COUNT_DEFAULT
) (
    input logic clk,
    input logic rst,
    color_bbox_tracker_if.slave bus
);
    state_t state;
    coord_t x;
    coord_t y;
    coord_t cx;
    coord_t cy;
    coord_t x_min_n;
    coord_t x_max_n;
    coord_t y_min_n;
    coord_t y_max_n;
    count_t count;
    count_t cnt_base;
    count_t cnt_n;
    logic accept;
    logic hit;
    logic fend;
    // a beat counts only inside a frame or when it opens one; sof forces coordinate (0,0)
    always_comb begin
        accept = bus.pix_valid && (bus.sof || state == IN_FRAME);
        hit = accept && bus.binary_in;
        cx = bus.sof ? '0 : x;
        cy = bus.sof ? '0 : y;
        fend = accept && bus.eol && cy == COORD_W'(V_ACTIVE - 1);
        cnt_base = bus.sof ? '0 : count;
        cnt_n = (hit && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
    end
    bbox_axis_minmax u_x (
        .clk(clk), .rst(rst), .clear(accept && bus.sof), .update(hit),
        .coord(cx), .min(x_min_n), .max(x_max_n)
    );
    bbox_axis_minmax u_y (
        .clk(clk), .rst(rst), .clear(accept && bus.sof), .update(hit),
        .coord(cy), .min(y_min_n), .max(y_max_n)
    );
    // frame FSM, raster counters and result registers loaded on the frame-end beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_SOF;
            x <= '0;
            y <= '0;
            count <= '0;
            bus.x_min <= '0;
            bus.x_max <= '0;
            bus.y_min <= '0;
            bus.y_max <= '0;
            bus.pix_count <= '0;
            bus.bbox_valid <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= fend;
            if (accept) begin
                count <= cnt_n;
                x <= bus.eol ? '0 : (cx == COORD_W'(H_ACTIVE - 1) ? cx : cx + 1'b1);
                y <= (bus.eol && cy != COORD_W'(V_ACTIVE - 1)) ? cy + 1'b1 : cy;
                state <= fend ? WAIT_SOF : IN_FRAME;
            end
            if (fend) begin
                bus.x_min <= cnt_n == '0 ? '0 : x_min_n;
                bus.x_max <= cnt_n == '0 ? '0 : x_max_n;
                bus.y_min <= cnt_n == '0 ? '0 : y_min_n;
                bus.y_max <= cnt_n == '0 ? '0 : y_max_n;
                bus.pix_count <= cnt_n;
                bus.bbox_valid <= cnt_n >= COUNT_W'(MIN_COUNT);
            end
        end
    end
endmodule

// File: doc/color_bbox_tracker.md
COLOR_BBOX_TRACKER -- requirements
Module: color_bbox_tracker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter MIN_COUNT, default 64, minimum matching pixels for a valid box.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pix_valid  input  1  one pixel beat this cycle.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid.
REQ-008 SHALL have port eol  input  1  last pixel of line, qualified by pix_valid.
REQ-009 SHALL have port binary_in  input  1  per-pixel colour-match bit from the binarisation stage (1 = match).
REQ-010 SHALL have ports x_min, x_max  output  12 each  box columns of last completed frame.
REQ-011 SHALL have ports y_min, y_max  output  12 each  box rows of last completed frame.
REQ-012 SHALL have port pix_count  output  21  matching pixels in last completed frame.
REQ-013 SHALL have port bbox_valid  output  1  high when pix_count >= MIN_COUNT.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when outputs update.

Function
REQ-015 SHALL keep column counter x and row counter y; on each pix_valid beat, the pixel's coordinate is (x,y).
REQ-016 SHALL treat a beat with sof=1 as coordinate (0,0) and clear all accumulators before including that pixel.
REQ-017 SHALL, after a beat with eol=1, set x=0 and y=y+1; otherwise x=x+1, saturating at H_ACTIVE-1.
REQ-018 SHALL saturate y at V_ACTIVE-1 (extra lines fold into the last row).
REQ-019 SHALL, on a matching beat, update min/max registers per axis and increment count, saturating at 2^21-1.
REQ-020 SHALL initialise frame accumulators to min=all-ones, max=0, count=0.
REQ-021 SHALL detect frame end as pix_valid & eol & y==V_ACTIVE-1, including that final pixel.
REQ-022 SHALL register outputs and assert frame_done exactly one cycle after the frame-end beat; outputs hold until the next frame_done.
REQ-023 SHALL output x_min=x_max=y_min=y_max=0 and bbox_valid=0 for a frame with zero matches.
REQ-024 SHALL, on sof before frame end (truncated frame), discard the partial accumulators with no frame_done.
REQ-025 SHALL, on sof and eol in the same beat, apply sof first, then end the line (next pixel at (0,1)).
REQ-026 SHALL ignore sof, eol and binary_in when pix_valid=0; counters hold.
REQ-027 SHALL ignore beats after frame end until the next sof.

Reset
REQ-028 SHALL, on rst, set x, y and accumulators to REQ-020 values, all outputs to 0, and the waiting-for-sof state.
REQ-029 SHALL, on rst mid-frame, abort the frame; no frame_done until a full frame completes after the next sof.

Structure
REQ-030 SHALL place coordinate width 12, count width 21 and MIN_COUNT default in shared package color_detect_pkg.
REQ-031 SHALL use sub-module bbox_axis_minmax (clear, update, coord in; min, max out) instantiated once per axis.
REQ-032 SHALL be a two-state FSM: WAIT_SOF, IN_FRAME.

Verification (H_ACTIVE=8, V_ACTIVE=4, MIN_COUNT=2)
REQ-033 SHALL test matches at (2,1),(5,1),(3,2) -> one cycle after frame end: x 2..5, y 1..2, count 3, bbox_valid 1, frame_done one pulse.
REQ-034 SHALL test an all-zero frame -> bounds 0, count 0, bbox_valid 0, frame_done pulses.
REQ-035 SHALL test a single match at (7,3) -> box 7..7 / 3..3, count 1, bbox_valid 0.
REQ-036 SHALL test sof on row 2, then a full frame with one match at (0,0) -> exactly one frame_done; box (0,0), count 1.
REQ-037 SHALL test rst asserted mid-frame -> outputs 0; next full frame reports correctly.
REQ-038 SHALL test pix_valid gaps with binary_in=1 while pix_valid=0 -> results identical to a gap-free run.
